// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: arbiter states, byte type and header default.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } arb_state_t;

    typedef logic [7:0] byte_t;

    // ASCII '0': header for requester i reads as the digit i
    localparam byte_t HDR_BASE_DEFAULT = 8'h30;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first asserted request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest candidate to ptr overwrites last
    always_comb begin
        valid = |req;
        idx   = '0;
        cand  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr) + i) % int'(N));
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants the UART transmitter to one requester per message, round-robin, with optional
// source-ID header byte and a stall timeout that drops a silent requester.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned HDR_EN    = 1,
    parameter byte_t       HDR_BASE  = HDR_BASE_DEFAULT,
    parameter int unsigned STALL_MAX = 1023
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    abort
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = (STALL_MAX == 0) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0] STALL_LAST = (STALL_MAX == 0) ? CW'(0) : CW'(STALL_MAX - 1);
    localparam logic [CW-1:0] CNT_SAT    = '1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NREQ - 1);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IW-1:0] grant_nxt;
    logic [CW-1:0] stall_cnt, stall_nxt;
    logic          abort_nxt;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          gnt_valid;
    logic          gnt_last;
    byte_t         gnt_data;
    logic [IW-1:0] grant_inc;

    assign gnt_valid = req_valid[grant_id];
    assign gnt_last  = req_last[grant_id];
    assign gnt_data  = req_data[{grant_id, 3'b000} +: 8];
    assign grant_inc = (grant_id == LAST_IDX) ? '0 : grant_id + IW'(1);

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State and registered status outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            stall_cnt <= '0;
            abort     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_id  <= grant_nxt;
            stall_cnt <= stall_nxt;
            abort     <= abort_nxt;
            busy      <= (state_nxt != ST_IDLE);
        end
    end

    // Next state and the combinational byte path
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_id;
        stall_nxt  = '0;
        abort_nxt  = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        req_ready  = '0;

        unique case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_nxt = pick_idx;
                    state_nxt = (HDR_EN != 0) ? ST_HDR : ST_BODY;
                end
            end

            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BASE + byte_t'(grant_id);
                if (tx_ready) begin
                    state_nxt = ST_BODY;
                end
            end

            ST_BODY: begin
                tx_valid            = gnt_valid;
                tx_data             = gnt_valid ? gnt_data : 8'h00;
                req_ready[grant_id] = tx_ready;
                // A last-byte handshake is checked first so it always beats the timeout
                if (gnt_valid && tx_ready && gnt_last) begin
                    state_nxt  = ST_IDLE;
                    rr_ptr_nxt = grant_inc;
                end else if (!gnt_valid) begin
                    if ((STALL_MAX != 0) && (stall_cnt == STALL_LAST)) begin
                        state_nxt  = ST_IDLE;
                        rr_ptr_nxt = grant_inc;
                        abort_nxt  = 1'b1;
                    end else begin
                        stall_nxt = (stall_cnt == CNT_SAT) ? stall_cnt : stall_cnt + CW'(1);
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table on a header/stall-4 instance plus
// sequences for backpressure and a header-less instance.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic [3:0]  vld0, lst0, rdy0, vld1, lst1, rdy1;
    logic [31:0] dat0, dat1;
    logic        txr0, txr1, txv0, txv1;
    logic [7:0]  txd0, txd1;
    logic        busy0, busy1, ab0, ab1;
    logic [1:0]  gid0, gid1;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(
        .NREQ(4), .HDR_EN(1), .HDR_BASE(8'h30), .STALL_MAX(4)
    ) dut0 (
        .CLK(clk), .RST_N(rst0),
        .req_valid(vld0), .req_data(dat0), .req_last(lst0), .req_ready(rdy0),
        .tx_valid(txv0), .tx_data(txd0), .tx_ready(txr0),
        .busy(busy0), .grant_id(gid0), .abort(ab0)
    );

    uart_tx_arbiter #(
        .NREQ(4), .HDR_EN(0), .HDR_BASE(8'h30), .STALL_MAX(4)
    ) dut1 (
        .CLK(clk), .RST_N(rst1),
        .req_valid(vld1), .req_data(dat1), .req_last(lst1), .req_ready(rdy1),
        .tx_valid(txv1), .tx_data(txd1), .tx_ready(txr1),
        .busy(busy1), .grant_id(gid1), .abort(ab1)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic [3:0]  lst;
        logic        txr;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic [3:0]  e_rdy;
        logic        e_busy;
        logic [1:0]  e_gid;
        logic        e_abort;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [3:0] v, input logic [31:0] d,
                                input logic [3:0] l, input logic t, input logic etv,
                                input logic [7:0] etd, input logic [3:0] erdy,
                                input logic eb, input logic [1:0] eg, input logic ea);
        vec_t x;
        x.rst_n = r;   x.vld = v;     x.dat = d;      x.lst = l;    x.txr = t;
        x.e_txv = etv; x.e_txd = etd; x.e_rdy = erdy; x.e_busy = eb;
        x.e_gid = eg;  x.e_abort = ea;
        tbl.push_back(x);
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic cyc1(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                        input logic t);
        @(posedge clk);
        #1;
        vld1 = v; dat1 = d; lst1 = l; txr1 = t;
        @(negedge clk);
    endtask

    // Source protocol: a stalled byte must hold its payload until accepted
    logic [3:0]  pv, pr, pl;
    logic [31:0] pd;
    logic        parm = 1'b0;
    always @(negedge clk) begin
        if (parm && rst0) begin
            for (int i = 0; i < 4; i++) begin
                if (pv[i] && !pr[i] && vld0[i]) begin
                    assert (dat0[8*i +: 8] == pd[8*i +: 8] && lst0[i] == pl[i])
                        else $error("source %0d changed payload while stalled", i);
                end
            end
        end
        pv   <= vld0;
        pr   <= rdy0;
        pd   <= dat0;
        pl   <= lst0;
        parm <= rst0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int         order [5] = '{0, 1, 2, 3, 0};
    int         prev_g;
    logic [31:0] b2;
    int         idx1;
    bit         done3;
    int         n;
    logic [3:0] mask;
    logic [7:0] got [$];
    logic [7:0] expq [$];

    initial begin
        rst0 = 1'b0; vld0 = '0; dat0 = '0; lst0 = '0; txr0 = 1'b0;
        rst1 = 1'b0; vld1 = '0; dat1 = '0; lst1 = '0; txr1 = 1'b0;

        // Single requester on port 2
        add(1, 4'b0100, 32'h0041_0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 2'd0, 0);
        add(1, 4'b0100, 32'h0041_0000, 4'b0000, 1, 1, 8'h32, 4'b0000, 1, 2'd2, 0);
        add(1, 4'b0100, 32'h0041_0000, 4'b0000, 1, 1, 8'h41, 4'b0100, 1, 2'd2, 0);
        add(1, 4'b0100, 32'h0042_0000, 4'b0100, 1, 1, 8'h42, 4'b0100, 1, 2'd2, 0);
        add(1, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 2'd2, 0);
        // Reset pulse in IDLE so contention starts from port 0
        add(0, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 2'd2, 0);

        // Contention: all four sources valid with 2-byte messages
        prev_g = 0;
        for (int k = 0; k < 5; k++) begin
            int g;
            g  = order[k];
            b2 = 32'hA3A2_A1A0;
            b2[8*g +: 8] = 8'hB0 + 8'(g);
            add(1, 4'b1111, 32'hA3A2_A1A0, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 2'(prev_g), 0);
            add(1, 4'b1111, 32'hA3A2_A1A0, 4'b0000, 1, 1, 8'h30 + 8'(g), 4'b0000, 1, 2'(g), 0);
            add(1, 4'b1111, 32'hA3A2_A1A0, 4'b0000, 1, 1, 8'hA0 + 8'(g), 4'(1 << g), 1, 2'(g), 0);
            add(1, 4'b1111, b2, 4'(1 << g), 1, 1, 8'hB0 + 8'(g), 4'(1 << g), 1, 2'(g), 0);
            prev_g = g;
        end
        add(1, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 2'd0, 0);

        // Stall: port 1 goes silent after one byte, port 3 waits
        add(1, 4'b1010, 32'h6600_5000, 4'b1000, 1, 0, 8'h00, 4'b0000, 0, 2'd0, 0);
        add(1, 4'b1010, 32'h6600_5000, 4'b1000, 1, 1, 8'h31, 4'b0000, 1, 2'd1, 0);
        add(1, 4'b1010, 32'h6600_5000, 4'b1000, 1, 1, 8'h50, 4'b0010, 1, 2'd1, 0);
        for (int k = 0; k < 4; k++) begin
            add(1, 4'b1000, 32'h6600_0000, 4'b1000, 1, 0, 8'h00, 4'b0010, 1, 2'd1, 0);
        end
        add(1, 4'b1000, 32'h6600_0000, 4'b1000, 1, 0, 8'h00, 4'b0000, 0, 2'd1, 1);
        add(1, 4'b1000, 32'h6600_0000, 4'b1000, 1, 1, 8'h33, 4'b0000, 1, 2'd3, 0);
        add(1, 4'b1000, 32'h6600_0000, 4'b1000, 1, 1, 8'h66, 4'b1000, 1, 2'd3, 0);
        add(1, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 2'd3, 0);

        // Reset mid-BODY after rr_ptr has moved to 3
        add(1, 4'b0100, 32'h0070_0000, 4'b0100, 1, 0, 8'h00, 4'b0000, 0, 2'd3, 0);
        add(1, 4'b0100, 32'h0070_0000, 4'b0100, 1, 1, 8'h32, 4'b0000, 1, 2'd2, 0);
        add(1, 4'b0100, 32'h0070_0000, 4'b0100, 1, 1, 8'h70, 4'b0100, 1, 2'd2, 0);
        add(1, 4'b1000, 32'h7100_0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 2'd2, 0);
        add(1, 4'b1000, 32'h7100_0000, 4'b0000, 1, 1, 8'h33, 4'b0000, 1, 2'd3, 0);
        add(1, 4'b1000, 32'h7100_0000, 4'b0000, 1, 1, 8'h71, 4'b1000, 1, 2'd3, 0);
        add(0, 4'b1000, 32'h7200_0000, 4'b0000, 1, 1, 8'h72, 4'b1000, 1, 2'd3, 0);
        add(1, 4'b1010, 32'h7300_1100, 4'b1010, 1, 0, 8'h00, 4'b0000, 0, 2'd0, 0);
        add(1, 4'b1010, 32'h7300_1100, 4'b1010, 1, 1, 8'h31, 4'b0000, 1, 2'd1, 0);
        add(1, 4'b1010, 32'h7300_1100, 4'b1010, 1, 1, 8'h11, 4'b0010, 1, 2'd1, 0);
        add(1, 4'b1000, 32'h7300_0000, 4'b1000, 1, 0, 8'h00, 4'b0000, 0, 2'd1, 0);
        add(1, 4'b1000, 32'h7300_0000, 4'b1000, 1, 1, 8'h33, 4'b0000, 1, 2'd3, 0);
        add(1, 4'b1000, 32'h7300_0000, 4'b1000, 1, 1, 8'h73, 4'b1000, 1, 2'd3, 0);
        add(1, 4'b0000, 32'h0000_0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 2'd3, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst0_txv",   0, txv0,  0);
        check("rst0_txd",   0, txd0,  0);
        check("rst0_rdy",   0, rdy0,  0);
        check("rst0_busy",  0, busy0, 0);
        check("rst0_gid",   0, gid0,  0);
        check("rst0_abort", 0, ab0,   0);
        check("rst1_busy",  0, busy1, 0);
        check("rst1_gid",   0, gid1,  0);
        check("rst1_abort", 0, ab1,   0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst0 = tbl[i].rst_n; vld0 = tbl[i].vld; dat0 = tbl[i].dat;
            lst0 = tbl[i].lst;   txr0 = tbl[i].txr;
            rst1 = 1'b1;
            @(negedge clk);
            check("txv",   i, txv0,  tbl[i].e_txv);
            check("txd",   i, txd0,  tbl[i].e_txd);
            check("rdy",   i, rdy0,  tbl[i].e_rdy);
            check("busy",  i, busy0, tbl[i].e_busy);
            check("gid",   i, gid0,  tbl[i].e_gid);
            check("abort", i, ab0,   tbl[i].e_abort);
        end

        // Backpressure: port 1 sends 5 bytes under random tx_ready, port 3 one byte after
        expq  = '{8'h31, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h33, 8'h77};
        idx1  = 0;
        done3 = 1'b0;
        n     = 0;
        while (!done3 && n < 300) begin
            @(posedge clk);
            #1;
            txr0 = 1'($urandom_range(0, 1));
            vld0 = {!done3, 1'b0, (idx1 < 5), 1'b0};
            dat0 = {8'h77, 8'h00, 8'h10 + 8'(idx1), 8'h00};
            lst0 = {1'b1, 1'b0, (idx1 == 4), 1'b0};
            @(negedge clk);
            mask = txr0 ? ((idx1 < 5) ? 4'b0010 : 4'b1000) : 4'b0000;
            check("bp_rdy_leak", n, rdy0 & ~mask, 0);
            if (!txv0) check("bp_txd_zero", n, txd0, 0);
            if (txv0 && txr0) got.push_back(txd0);
            if (vld0[1] && rdy0[1]) idx1++;
            if (vld0[3] && rdy0[3]) done3 = 1'b1;
            n++;
        end
        check("bp_done", 0, done3, 1);
        check("bp_count", 0, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < got.size()) check("bp_byte", i, got[i], expq[i]);
        end
        @(posedge clk);
        #1;
        vld0 = '0; dat0 = '0; lst0 = '0; txr0 = 1'b0;

        // No header: byte follows the grant; last byte on the would-be timeout cycle
        cyc1(4'b0001, 32'h0000_00C0, 4'b0000, 1);
        check("nh_idle_txv",  0, txv1,  0);
        check("nh_idle_busy", 0, busy1, 0);
        cyc1(4'b0001, 32'h0000_00C0, 4'b0000, 1);
        check("nh_first_txv",  0, txv1,  1);
        check("nh_first_txd",  0, txd1,  8'hC0);
        check("nh_first_rdy",  0, rdy1,  4'b0001);
        check("nh_first_busy", 0, busy1, 1);
        check("nh_first_gid",  0, gid1,  0);
        for (int k = 0; k < 3; k++) begin
            cyc1(4'b0000, 32'h0, 4'b0000, 1);
            check("nh_stall_txv",   k, txv1,  0);
            check("nh_stall_txd",   k, txd1,  0);
            check("nh_stall_busy",  k, busy1, 1);
            check("nh_stall_abort", k, ab1,   0);
        end
        cyc1(4'b0001, 32'h0000_00C1, 4'b0001, 1);
        check("nh_last_txd",   0, txd1, 8'hC1);
        check("nh_last_rdy",   0, rdy1, 4'b0001);
        check("nh_last_abort", 0, ab1,  0);
        cyc1(4'b0000, 32'h0, 4'b0000, 1);
        check("nh_done_busy",  0, busy1, 0);
        check("nh_done_abort", 0, ab1,   0);
        check("nh_done_txv",   0, txv1,  0);
        cyc1(4'b0000, 32'h0, 4'b0000, 1);
        check("nh_after_abort", 0, ab1,  0);
        check("nh_after_busy",  0, busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
